riscv_wb_unit: RTL and testbench

//   Write-back end of the datapath: the counterpart of the operand-select muxes that feed the ALU.
//   - Accepts one completed instruction from the MEM stage per valid/ready handshake.
//   - For loads, waits for the data-memory response, then aligns and sign/zero-extends the data.
//   - Selects the result by WB_SEL and drives the register-file write port for exactly one cycle.
//

---
 rtl/riscv_constants.sv | 17 +
 rtl/riscv_load_align.sv | 31 +++
 rtl/riscv_wb_unit.sv | 148 ++++++++++++++
 tb/tb_riscv_wb_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_constants.sv
// Shared RISC-V datapath constants: write-back source select and load funct3 encodings.
package riscv_constants;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_t;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load extraction: picks the byte/halfword lane from a word-aligned read
// and sign- or zero-extends it according to the load funct3.
module riscv_load_align
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic [WORD_LENGTH-1:0] rdata,
  input  logic [2:0]             funct3,
  input  logic [1:0]             addr_lo,
  output logic [WORD_LENGTH-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data      = '0;
    case (funct3)
      LD_B:    data = {{(WORD_LENGTH-8){byte_lane[7]}}, byte_lane};
      LD_H:    data = {{(WORD_LENGTH-16){half_lane[15]}}, half_lane};
      LD_W:    data = rdata;
      LD_BU:   data = {{(WORD_LENGTH-8){1'b0}}, byte_lane};
      LD_HU:   data = {{(WORD_LENGTH-16){1'b0}}, half_lane};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/riscv_wb_unit.sv
// Write-back stage: accepts retired instructions, waits on load responses and drives the
// register-file write port. Define RISCV_WB_INSTRET_EN to add the 64-bit instret counter.
module riscv_wb_unit
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  wb_sel_t                wb_sel,
  input  logic [4:0]             rd_addr,
  input  logic                   rd_wen,
  input  logic [WORD_LENGTH-1:0] alu_result,
  input  logic [WORD_LENGTH-1:0] pc,
  input  logic [WORD_LENGTH-1:0] csr_rdata,
  input  logic [2:0]             load_funct3,
  input  logic [1:0]             mem_addr_lo,
  input  logic                   mem_rvalid,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   rf_wen,
  output logic [4:0]             rf_waddr,
  output logic [WORD_LENGTH-1:0] rf_wdata,
  output logic                   busy
`ifdef RISCV_WB_INSTRET_EN
  ,
  output logic [63:0]            instret
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_LOAD = 2'd2
  } wb_state_t;

  wb_state_t state, state_next;

  logic [4:0]             pend_rd;
  logic                   pend_wen;
  logic [2:0]             pend_funct3;
  logic [1:0]             pend_addr_lo;
  logic                   accept;
  logic                   wen_next;
  logic [4:0]             waddr_next;
  logic [WORD_LENGTH-1:0] wdata_next;
  logic [WORD_LENGTH-1:0] sel_result;
  logic [WORD_LENGTH-1:0] load_data;

  assign in_ready = (state != WAIT_LOAD);
  assign busy     = (state == WAIT_LOAD);
  assign accept   = in_valid && in_ready;

  riscv_load_align #(.WORD_LENGTH(WORD_LENGTH)) u_load_align (
    .rdata   (mem_rdata),
    .funct3  (pend_funct3),
    .addr_lo (pend_addr_lo),
    .data    (load_data)
  );

  always_comb begin
    sel_result = '0;
    case (wb_sel)
      WB_ALU:  sel_result = alu_result;
      WB_PC4:  sel_result = pc + WORD_LENGTH'(4);
      WB_CSR:  sel_result = csr_rdata;
      default: sel_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    wen_next   = 1'b0;
    waddr_next = rd_addr;
    wdata_next = sel_result;
    case (state)
      IDLE, WRITE: begin
        state_next = IDLE;
        if (accept) begin
          if (wb_sel == WB_MEM) begin
            state_next = WAIT_LOAD;
          end else begin
            state_next = WRITE;
            wen_next   = rd_wen && (rd_addr != 5'd0);
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_next = WRITE;
          wen_next   = pend_wen && (pend_rd != 5'd0);
          waddr_next = pend_rd;
          wdata_next = load_data;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Load context is held until the response arrives, since the MEM stage moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_rd      <= '0;
      pend_wen     <= 1'b0;
      pend_funct3  <= '0;
      pend_addr_lo <= '0;
    end else if (accept && (wb_sel == WB_MEM)) begin
      pend_rd      <= rd_addr;
      pend_wen     <= rd_wen;
      pend_funct3  <= load_funct3;
      pend_addr_lo <= mem_addr_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= wen_next;
      if (wen_next) begin
        rf_waddr <= waddr_next;
        rf_wdata <= wdata_next;
      end
    end
  end

`ifdef RISCV_WB_INSTRET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (state == WRITE) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_wb_unit.sv
// Self-checking bench for riscv_wb_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural write-back model.
module tb_riscv_wb_unit;
  import riscv_constants::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  wb_sel_t     wb_sel = WB_ALU;
  logic [4:0]  rd_addr = '0;
  logic        rd_wen = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] pc = '0;
  logic [31:0] csr_rdata = '0;
  logic [2:0]  load_funct3 = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  riscv_wb_unit #(.WORD_LENGTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wb_sel      (wb_sel),
    .rd_addr     (rd_addr),
    .rd_wen      (rd_wen),
    .alu_result  (alu_result),
    .pc          (pc),
    .csr_rdata   (csr_rdata),
    .load_funct3 (load_funct3),
    .mem_addr_lo (mem_addr_lo),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy)
`ifdef RISCV_WB_INSTRET_EN
    ,
    .instret     (instret)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: what the register file should see, derived from the transaction rules.
  bit          m_loading = 1'b0;
  bit          m_retire = 1'b0;
  bit          m_rf_wen = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [4:0]  m_p_rd = '0;
  bit          m_p_wen = 1'b0;
  logic [2:0]  m_p_f3 = '0;
  logic [1:0]  m_p_lo = '0;
  logic [63:0] m_instret = '0;
  bit          n_retire;
  bit          n_wen;
  logic [4:0]  n_addr;
  logic [31:0] n_val;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input wb_sel_t s, input logic [31:0] a,
                                               input logic [31:0] p, input logic [31:0] c);
    case (s)
      WB_ALU:  return a;
      WB_PC4:  return p + 32'd4;
      WB_CSR:  return c;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 1'b0;
      m_retire  = 1'b0;
      m_rf_wen  = 1'b0;
      m_waddr   = '0;
      m_wdata   = '0;
      m_instret = '0;
    end else begin
      n_retire = 1'b0;
      n_wen    = 1'b0;
      n_addr   = rd_addr;
      n_val    = 32'd0;
      if (!m_loading) begin
        if (in_valid && wb_sel == WB_MEM) begin
          m_loading = 1'b1;
          m_p_rd    = rd_addr;
          m_p_wen   = rd_wen;
          m_p_f3    = load_funct3;
          m_p_lo    = mem_addr_lo;
        end else if (in_valid) begin
          n_retire = 1'b1;
          n_wen    = rd_wen && rd_addr != 0;
          n_val    = model_result(wb_sel, alu_result, pc, csr_rdata);
        end
      end else if (mem_rvalid) begin
        m_loading = 1'b0;
        n_retire  = 1'b1;
        n_wen     = m_p_wen && m_p_rd != 0;
        n_addr    = m_p_rd;
        n_val     = model_load(mem_rdata, m_p_f3, m_p_lo);
      end
      if (m_retire) m_instret = m_instret + 64'd1;
      if (n_wen) begin
        m_waddr = n_addr;
        m_wdata = n_val;
      end
      m_retire = n_retire;
      m_rf_wen = n_wen;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cmp_in_ready", 64'(in_ready), 64'(!m_loading));
    checkOutput("cmp_busy", 64'(busy), 64'(m_loading));
    checkOutput("cmp_rf_wen", 64'(rf_wen), 64'(m_rf_wen));
    checkOutput("cmp_rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    checkOutput("cmp_rf_wdata", 64'(rf_wdata), 64'(m_wdata));
`ifdef RISCV_WB_INSTRET_EN
    checkOutput("cmp_instret", instret, m_instret);
`endif
  end

  task automatic applyStimulus(input bit v, input wb_sel_t s, input logic [4:0] rd,
                               input bit wen, input logic [31:0] alu, input logic [31:0] pcv,
                               input logic [31:0] csr, input logic [2:0] f3,
                               input logic [1:0] lo, input bit rv, input logic [31:0] rdata);
    in_valid    = v;
    wb_sel      = s;
    rd_addr     = rd;
    rd_wen      = wen;
    alu_result  = alu;
    pc          = pcv;
    csr_rdata   = csr;
    load_funct3 = f3;
    mem_addr_lo = lo;
    mem_rvalid  = rv;
    mem_rdata   = rdata;
  endtask

  task automatic idle();
    applyStimulus(0, WB_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic runByteLoad(input logic [2:0] f3, input logic [31:0] expected, input string tag);
    applyStimulus(1, WB_MEM, 7, 1, 0, 0, 0, f3, 2'd3, 1, 32'h12345678);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
      checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      if (i == 2) applyStimulus(0, WB_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF0000);
      step();
    end
    idle();
    checkOutput({tag, "_wen"}, 64'(rf_wen), 64'd1);
    checkOutput({tag, "_waddr"}, 64'(rf_waddr), 64'd7);
    checkOutput({tag, "_wdata"}, 64'(rf_wdata), 64'(expected));
    checkOutput({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    wb_sel_t rs;
    idle();
    step();
    checkOutput("reset_wen", 64'(rf_wen), 64'd0);
    checkOutput("reset_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("reset_wdata", 64'(rf_wdata), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    checkOutput("model_lh_hi", 64'(model_load(32'h80017FFE, LD_H, 2'd2)), 64'hFFFF8001);
    checkOutput("model_lhu_lo", 64'(model_load(32'h80017FFE, LD_HU, 2'd0)), 64'h00007FFE);
    checkOutput("model_lb_b1", 64'(model_load(32'h00007F00, LD_B, 2'd1)), 64'h0000007F);

    applyStimulus(1, WB_ALU, 5, 1, 32'h12345678, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    checkOutput("alu_wen", 64'(rf_wen), 64'd1);
    checkOutput("alu_waddr", 64'(rf_waddr), 64'd5);
    checkOutput("alu_wdata", 64'(rf_wdata), 64'h12345678);
    step();
    checkOutput("alu_wen_drop", 64'(rf_wen), 64'd0);
    checkOutput("alu_wdata_hold", 64'(rf_wdata), 64'h12345678);

    runByteLoad(LD_B, 32'hFFFFFF80, "lb");
    runByteLoad(LD_BU, 32'h00000080, "lbu");

    applyStimulus(1, WB_PC4, 1, 1, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, WB_CSR, 2, 1, 0, 0, 32'h0000DEAD, 0, 0, 0, 0);
    checkOutput("pc4_wen", 64'(rf_wen), 64'd1);
    checkOutput("pc4_wdata", 64'(rf_wdata), 64'h0);
    checkOutput("pc4_waddr", 64'(rf_waddr), 64'd1);
    step();
    idle();
    checkOutput("csr_wen", 64'(rf_wen), 64'd1);
    checkOutput("csr_wdata", 64'(rf_wdata), 64'h0000DEAD);
    checkOutput("csr_waddr", 64'(rf_waddr), 64'd2);

    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1, WB_ALU, 0, 1, 32'hAAAA5555, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    checkOutput("x0_wen", 64'(rf_wen), 64'd0);
    checkOutput("x0_wdata", 64'(rf_wdata), 64'd0);
    step();
`ifdef RISCV_WB_INSTRET_EN
    checkOutput("x0_instret", instret, 64'd1);
`endif

    applyStimulus(0, WB_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    step();
    idle();
    checkOutput("stray_wen", 64'(rf_wen), 64'd0);
    checkOutput("stray_busy", 64'(busy), 64'd0);
    applyStimulus(1, WB_MEM, 9, 1, 0, 0, 0, LD_W, 0, 0, 0);
    step();
    idle();
    step();
    checkOutput("midload_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_wen", 64'(rf_wen), 64'd0);
    checkOutput("rst_wdata", 64'(rf_wdata), 64'd0);
    checkOutput("rst_waddr", 64'(rf_waddr), 64'd0);
    step();
    rst = 1'b0;
    applyStimulus(0, WB_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00000055);
    step();
    idle();
    checkOutput("post_rst_wen", 64'(rf_wen), 64'd0);
    checkOutput("post_rst_wdata", 64'(rf_wdata), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      rs = wb_sel_t'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 9) < 7, rs,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    $urandom_range(0, 4) != 0, $urandom,
                    ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom, $urandom,
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 4, $urandom);
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
